// File: rtl/cache_axi_pkg.sv
// rtl/cache_axi_pkg.sv - shared encodings for the cache read-port arbiter
package cache_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] ID_I_DEF       = 4'd0;
  localparam logic [3:0] ID_D_DEF       = 4'd1;

  function automatic logic [2:0] axi_size(input int bytes);
    return 3'($clog2(bytes));
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant; on a tie the side that did not win last time wins
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  // bit 0 = I-cache, bit 1 = D-cache; last_grant_i = 1 means D won last
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_grant_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/cache_rd_arbiter.sv
// rtl/cache_rd_arbiter.sv - shares one AXI4 read port between I-cache and D-cache refill FSMs
module cache_rd_arbiter
  import cache_axi_pkg::*;
#(
  parameter int          ADDR_W     = 32,
  parameter int          DATA_W     = 32,
  parameter int          LINE_WORDS = 16,
  parameter logic [3:0]  ID_I       = ID_I_DEF,
  parameter logic [3:0]  ID_D       = ID_D_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              i_rd_rdy,
  input  logic              i_ret_ready,
  output logic              i_ret_valid,
  input  logic              d_rd_req,
  input  logic [ADDR_W-1:0] d_rd_addr,
  input  logic              d_rd_uncached,
  output logic              d_rd_rdy,
  input  logic              d_ret_ready,
  output logic              d_ret_valid,
  output logic [DATA_W-1:0] ret_data,
  output logic              ret_last,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [3:0]        arid,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rlast,
  input  logic [1:0]        rresp,
  input  logic [3:0]        rid,
  output logic              rd_err
);

  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * DATA_W / 8 - 1);
  localparam logic [7:0]        LINE_LEN  = 8'(LINE_WORDS - 1);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [3:0]        arid_q, arid_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic              rd_err_q, rd_err_d;

  logic [1:0]        gnt;
  logic              beat;
  logic              grant_d_side;
  logic [ADDR_W-1:0] req_addr;

  rr_arb2 u_rr_arb2 (
    .req_i        ({d_rd_req, i_rd_req}),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt)
  );

  assign grant_d_side = gnt[1];
  assign req_addr     = grant_d_side ? d_rd_addr : i_rd_addr;

  assign araddr   = addr_q;
  assign arlen    = len_q;
  assign arid     = arid_q;
  assign arsize   = axi_size(DATA_W / 8);
  assign arburst  = AXI_BURST_INCR;
  assign ret_data = rdata;
  assign ret_last = rlast;
  assign rd_err   = rd_err_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    len_d        = len_q;
    arid_d       = arid_q;
    beat_cnt_d   = beat_cnt_q;
    rd_err_d     = rd_err_q;
    arvalid      = 1'b0;
    rready       = 1'b0;
    i_rd_rdy     = 1'b0;
    d_rd_rdy     = 1'b0;
    i_ret_valid  = 1'b0;
    d_ret_valid  = 1'b0;
    beat         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          owner_d = owner_e'(grant_d_side);
          arid_d  = grant_d_side ? ID_D : ID_I;
          // uncached D reads fetch exactly the addressed word; everything else is an aligned line
          if (grant_d_side && d_rd_uncached) begin
            addr_d = req_addr;
            len_d  = 8'd0;
          end else begin
            addr_d = req_addr & ~LINE_MASK;
            len_d  = LINE_LEN;
          end
          state_d = ST_ADDR;
        end
      end

      ST_ADDR: begin
        arvalid = 1'b1;
        if (arready) begin
          i_rd_rdy   = (owner_q == OWN_I);
          d_rd_rdy   = (owner_q == OWN_D);
          beat_cnt_d = 8'd0;
          state_d    = ST_DATA;
        end
      end

      ST_DATA: begin
        rready      = (owner_q == OWN_D) ? d_ret_ready : i_ret_ready;
        i_ret_valid = (owner_q == OWN_I) && rvalid;
        d_ret_valid = (owner_q == OWN_D) && rvalid;
        beat        = rvalid && rready;
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          // a count overrun without rlast is flagged but the burst keeps draining until rlast
          if ((rresp != AXI_RESP_OKAY) || (rid != arid_q) ||
              (rlast && (beat_cnt_q != len_q)) ||
              (!rlast && (beat_cnt_q == len_q))) begin
            rd_err_d = 1'b1;
          end
          if (rlast) begin
            last_grant_d = owner_q;
            state_d      = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_I;
      last_grant_q <= OWN_D;
      addr_q       <= '0;
      len_q        <= '0;
      arid_q       <= '0;
      beat_cnt_q   <= '0;
      rd_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      arid_q       <= arid_d;
      beat_cnt_q   <= beat_cnt_d;
      rd_err_q     <= rd_err_d;
    end
  end

endmodule
